// File: rtl/tmds_decoder_if.sv
// Serial TMDS bit in, decoded pixel/control symbol out; one-cycle valid strobe, no backpressure.
interface tmds_decoder_if;
    logic       enc;
    logic       valid;
    logic       locked;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] dec;

    modport slave  (input enc, output valid, locked, de, ctrl, dec);
    modport master (output enc, input valid, locked, de, ctrl, dec);
endinterface

// File: rtl/tmds_decoder.sv
// TMDS channel receiver: token-hunt word alignment, then symbol decode; outputs 1 edge after a boundary.
// Strobe-only output (no backpressure): the sink must accept every valid pulse.
module tmds_decoder #(
    parameter int LOCK_COUNT = 8,
    parameter int TIMEOUT    = 4096
) (
    input logic         clk,
    input logic         reset,
    tmds_decoder_if.slave rx
);
    localparam int TOW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t         state_q, state_d;
    logic [9:0]     sr_q, sr_d;
    logic [3:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     matchcnt_q, matchcnt_d;
    logic [TOW-1:0] tocnt_q, tocnt_d;
    logic           valid_q, valid_d;
    logic           de_q, de_d;
    logic [1:0]     ctrl_q, ctrl_d;
    logic [7:0]     dec_q, dec_d;

    logic           is_tok;
    logic [1:0]     tok_code;
    logic [7:0]     q;
    logic [7:0]     dat;
    logic           boundary;
    logic           present;

    always_comb begin
        is_tok   = 1'b1;
        tok_code = 2'd0;
        case (sr_q)
            10'b1101010100: tok_code = 2'd0;
            10'b0010101011: tok_code = 2'd1;
            10'b0101010100: tok_code = 2'd2;
            10'b1010101011: tok_code = 2'd3;
            default:        is_tok   = 1'b0;
        endcase
    end

    // Undo the optional inversion (bit 9), then the XOR/XNOR chain selected by bit 8.
    always_comb begin
        q      = sr_q[9] ? ~sr_q[7:0] : sr_q[7:0];
        dat    = 8'd0;
        dat[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            dat[i] = sr_q[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

    assign boundary = (bitcnt_q == 4'd0);

    always_comb begin
        state_d    = state_q;
        sr_d       = {rx.enc, sr_q[9:1]};
        bitcnt_d   = (bitcnt_q == 4'd9) ? 4'd0 : bitcnt_q + 4'd1;
        matchcnt_d = matchcnt_q;
        tocnt_d    = tocnt_q;
        valid_d    = 1'b0;
        de_d       = de_q;
        ctrl_d     = ctrl_q;
        dec_d      = dec_q;
        present    = 1'b0;

        case (state_q)
            HUNT: begin
                bitcnt_d   = 4'd0;
                matchcnt_d = 8'd0;
                tocnt_d    = '0;
                if (is_tok) begin
                    bitcnt_d   = 4'd1;
                    matchcnt_d = 8'd1;
                    state_d    = VERIFY;
                end
            end
            VERIFY: begin
                if (boundary) begin
                    if (is_tok) begin
                        matchcnt_d = matchcnt_q + 8'd1;
                        if (int'(matchcnt_q) + 1 == LOCK_COUNT) begin
                            state_d = LOCKED;
                            tocnt_d = '0;
                            present = 1'b1;
                        end
                    end else begin
                        state_d    = HUNT;
                        matchcnt_d = 8'd0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    present = 1'b1;
                    if (is_tok) begin
                        tocnt_d = '0;
                    end else if (int'(tocnt_q) + 1 == TIMEOUT) begin
                        state_d = HUNT;
                        tocnt_d = '0;
                    end else if (tocnt_q != {TOW{1'b1}}) begin
                        tocnt_d = tocnt_q + TOW'(1);
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        if (present) begin
            valid_d = 1'b1;
            if (is_tok) begin
                de_d   = 1'b0;
                ctrl_d = tok_code;
            end else begin
                de_d  = 1'b1;
                dec_d = dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HUNT;
            sr_q       <= '0;
            bitcnt_q   <= '0;
            matchcnt_q <= '0;
            tocnt_q    <= '0;
            valid_q    <= 1'b0;
            de_q       <= 1'b0;
            ctrl_q     <= '0;
            dec_q      <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bitcnt_q   <= bitcnt_d;
            matchcnt_q <= matchcnt_d;
            tocnt_q    <= tocnt_d;
            valid_q    <= valid_d;
            de_q       <= de_d;
            ctrl_q     <= ctrl_d;
            dec_q      <= dec_d;
        end
    end

    assign rx.valid  = valid_q;
    assign rx.locked = (state_q == LOCKED);
    assign rx.de     = de_q;
    assign rx.ctrl   = ctrl_q;
    assign rx.dec    = dec_q;
endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: bit-level reference model compared every cycle, plus a symbol scoreboard fed by a TMDS encoder model.
module tb_tmds_decoder;
    localparam int LC = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tmds_decoder_if ifc();
    tmds_decoder #(.LOCK_COUNT(LC), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .rx(ifc));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [9:0] toks [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    function automatic int tok_index(input logic [9:0] w);
        for (int k = 0; k < 4; k++) if (w == toks[k]) return k;
        return -1;
    endfunction

    function automatic logic [7:0] ref_dec(input logic [9:0] w);
        logic [7:0] qv;
        logic [7:0] r;
        logic       x;
        qv = w[9] ? ~w[7:0] : w[7:0];
        r  = 8'd0;
        r[0] = qv[0];
        for (int i = 1; i < 8; i++) begin
            x = qv[i] ^ qv[i-1];
            r[i] = w[8] ? x : ~x;
        end
        return r;
    endfunction

    // Transmitter model (DVI channel encoder with running disparity).
    int enc_cnt = 0;
    function automatic logic [9:0] enc_data(input logic [7:0] d);
        logic [8:0] qm;
        logic [9:0] o;
        int n1, n1q, n0q;
        bit use_xnor;
        n1 = $countones(d);
        use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~use_xnor;
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (enc_cnt == 0 || n1q == n0q) begin
            o = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            enc_cnt = qm[8] ? enc_cnt + n1q - n0q : enc_cnt + n0q - n1q;
        end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
            o = {1'b1, qm[8], ~qm[7:0]};
            enc_cnt = enc_cnt + (qm[8] ? 2 : 0) + n0q - n1q;
        end else begin
            o = {1'b0, qm[8], qm[7:0]};
            enc_cnt = enc_cnt - (qm[8] ? 0 : 2) + n1q - n0q;
        end
        return o;
    endfunction

    function automatic logic [9:0] enc_ctrl(input int c);
        enc_cnt = 0;
        return toks[c];
    endfunction

    // Reference receiver state: mode 0 = hunting, 1 = verifying, 2 = locked.
    int         m_mode = 0, m_phase = 0, m_match = 0, m_to = 0;
    logic [9:0] m_sr = '0;
    logic       m_valid = 0, m_de = 0;
    logic [1:0] m_ctrl = '0;
    logic [7:0] m_dec = '0;

    function automatic void m_present(input logic [9:0] w, input int t);
        m_valid = 1'b1;
        if (t >= 0) begin
            m_de = 1'b0;
            m_ctrl = t[1:0];
        end else begin
            m_de = 1'b1;
            m_dec = ref_dec(w);
        end
    endfunction

    function automatic void model_step(input bit b, input bit rst);
        logic [9:0] w;
        int t;
        w = m_sr;
        m_valid = 1'b0;
        if (rst) begin
            m_mode = 0; m_phase = 0; m_match = 0; m_to = 0;
            m_sr = '0; m_de = 0; m_ctrl = '0; m_dec = '0;
            return;
        end
        t = tok_index(w);
        if (m_mode == 0) begin
            if (t >= 0) begin
                m_mode = 1; m_phase = 1; m_match = 1;
            end
        end else begin
            if (m_phase == 0) begin
                if (m_mode == 1) begin
                    if (t >= 0) begin
                        m_match++;
                        if (m_match == LC) begin
                            m_mode = 2; m_to = 0;
                            m_present(w, t);
                        end
                    end else begin
                        m_mode = 0; m_match = 0;
                    end
                end else begin
                    m_present(w, t);
                    if (t >= 0) m_to = 0;
                    else begin
                        m_to++;
                        if (m_to == TO) begin
                            m_mode = 0; m_to = 0;
                        end
                    end
                end
            end
            m_phase = (m_phase + 1) % 10;
        end
        m_sr = {b, w[9:1]};
    endfunction

    typedef struct { bit is_data; logic [7:0] val; } exp_t;
    exp_t sbq[$];
    bit   sb_en = 0;
    int   cyc = 0;
    int   lock_cyc = -1;

    function automatic void sb_push(input bit is_data, input logic [7:0] val);
        exp_t e;
        e.is_data = is_data;
        e.val = val;
        sbq.push_back(e);
    endfunction

    task automatic send_bit(input bit b, input bit rst = 1'b0);
        exp_t e;
        ifc.enc = b;
        reset = rst;
        @(posedge clk);
        cyc++;
        model_step(b, rst);
        #1;
        check("valid", ifc.valid, m_valid);
        check("locked", ifc.locked, (m_mode == 2));
        check("de", ifc.de, m_de);
        check("ctrl", ifc.ctrl, m_ctrl);
        check("dec", ifc.dec, m_dec);
        if (ifc.locked && lock_cyc < 0) lock_cyc = cyc;
        if (sb_en) begin
            if (sbq.size() == 0) check("sb_unexpected_valid", ifc.valid, 0);
            else if (ifc.valid) begin
                e = sbq.pop_front();
                check("sb_de", ifc.de, e.is_data);
                if (e.is_data) check("sb_dec", ifc.dec, e.val);
                else check("sb_ctrl", ifc.ctrl, e.val[1:0]);
            end
        end
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int k = 0; k < 10; k++) send_bit(w[k]);
    endtask

    initial begin
        int c0, vcount, run, c;
        logic [7:0] b;
        logic [7:0] bytes [5] = '{8'h00, 8'hFF, 8'h55, 8'hA5, 8'h10};
        logic [9:0] w;

        ifc.enc = 1'b0;
        // Reset with random line activity, then a quiet line.
        for (int i = 0; i < 3; i++) send_bit(1'($urandom % 2), 1'b1);
        check("rst_valid", ifc.valid, 0);
        check("rst_locked", ifc.locked, 0);
        check("rst_de", ifc.de, 0);
        check("rst_ctrl", ifc.ctrl, 0);
        check("rst_dec", ifc.dec, 0);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b0);
            vcount += int'(ifc.valid);
        end
        check("quiet_valids", vcount, 0);

        // Acquire: junk bits then ctrl-00 tokens.
        c0 = cyc;
        lock_cyc = -1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int i = 0; i < 10; i++) send_word(toks[0]);
        check("lock_rise_cycle", lock_cyc - c0, 13 + 10 * (LC - 1) + 1);
        check("locked_after_acq", ifc.locked, 1);
        sb_en = 1;
        sb_push(0, 8'd0);

        // Direct data words.
        sb_push(1, 8'h00); send_word(10'b0100000000);
        sb_push(1, 8'hFE); send_word(10'b1011111111);

        // Encoder loopback: data then all control codes.
        enc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            w = enc_data(bytes[i]);
            sb_push(1, bytes[i]);
            send_word(w);
        end
        for (int k = 0; k < 4; k++) begin
            sb_push(0, 8'(k));
            send_word(enc_ctrl(k));
        end

        // Random pixel stream, token inserted well before the timeout.
        run = 0;
        for (int i = 0; i < 40; i++) begin
            if (run >= 10 || $urandom_range(9) < 3) begin
                c = $urandom_range(3);
                sb_push(0, 8'(c));
                send_word(enc_ctrl(c));
                run = 0;
            end else begin
                b = 8'($urandom);
                sb_push(1, b);
                send_word(enc_data(b));
                run++;
            end
        end

        // Timeout: one token then TO data symbols.
        c = $urandom_range(3);
        sb_push(0, 8'(c));
        send_word(enc_ctrl(c));
        for (int i = 0; i < TO; i++) begin
            b = 8'($urandom);
            sb_push(1, b);
            send_word(enc_data(b));
        end
        send_word(toks[1]);
        check("sb_drained", sbq.size(), 0);
        check("timeout_locked", ifc.locked, 0);
        sb_en = 0;
        for (int i = 0; i < 12; i++) send_word(toks[2]);
        check("relock_after_timeout", ifc.locked, 1);

        // Verify failure: one token followed by data.
        send_bit(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) send_bit(1'b0);
        lock_cyc = -1;
        send_word(toks[3]);
        send_word(10'b0100000000);
        for (int i = 0; i < 20; i++) send_bit(1'b0);
        check("verify_fail_no_lock", lock_cyc, -1);
        c0 = cyc;
        for (int i = 0; i < 9; i++) send_word(toks[3]);
        check("verify_relock_cycle", lock_cyc - c0, 10 + 10 * (LC - 1) + 1);

        // Reset mid-symbol while locked (bit counter at 4).
        w = toks[0];
        for (int k = 0; k < 4; k++) send_bit(w[k]);
        send_bit(w[4], 1'b1);
        check("midrst_valid", ifc.valid, 0);
        check("midrst_locked", ifc.locked, 0);
        check("midrst_de", ifc.de, 0);
        check("midrst_ctrl", ifc.ctrl, 0);
        check("midrst_dec", ifc.dec, 0);
        for (int i = 0; i < 5; i++) send_bit(w[5 + i]);
        check("midrst_stays_unlocked", ifc.locked, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
